// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative restoring divider for the EX stage. Produces
//            {remainder, quotient} for signed or unsigned operands, reports
//            divide-by-zero, and holds the result until start is dropped.
// Revision : 1.0  initial release
// ============================================================================
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 annul_i,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 div_zero_o
);

   localparam int            C_CW   = $clog2(WIDTH + 1);
   localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t              r_state;
   logic [C_CW-1:0]     r_cnt;
   logic [WIDTH-1:0]    r_rem;       // partial remainder
   logic [WIDTH-1:0]    r_dvd;       // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0]    r_divisor;   // divisor magnitude
   logic                r_neg_q;     // quotient needs negation at the end
   logic                r_neg_r;     // remainder needs negation at the end
   logic                r_dz;        // current result came from a zero divisor

   logic [WIDTH-1:0]    w_mag1;
   logic [WIDTH-1:0]    w_mag2;
   logic [WIDTH:0]      w_shift;
   logic                w_ge;
   logic [WIDTH-1:0]    w_diff;
   logic [WIDTH-1:0]    w_quo_fix;
   logic [WIDTH-1:0]    w_rem_fix;

   // Operand magnitudes: two's-complement abs() only for signed divides.
   // The most negative value maps onto itself, which read as unsigned is
   // exactly its magnitude, so overflow needs no special case.
   assign w_mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign w_mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // One restoring step: bring the next dividend bit into the remainder and
   // subtract the divisor if it fits (trial difference taken over W+1 bits).
   assign w_shift = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_divisor});
   assign w_diff  = WIDTH'(w_shift - {1'b0, r_divisor});

   // Sign correction: quotient sign follows operand sign mismatch, remainder
   // takes the sign of the dividend.
   assign w_quo_fix = r_neg_q ? -r_dvd : r_dvd;
   assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

   // Busy is decoded directly from the state.
   assign busy_o = (r_state != S_FREE);

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FREE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_dvd      <= '0;
         r_divisor  <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         result_o   <= '0;
         ready_o    <= 1'b0;
         div_zero_o <= 1'b0;
      end else begin
         case (r_state)
            S_FREE: begin
               result_o   <= '0;
               ready_o    <= 1'b0;
               div_zero_o <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_state <= S_BYZERO;
                  end else begin
                     r_state   <= S_ON;
                     r_neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                     r_neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
                     r_rem     <= '0;
                     r_dvd     <= w_mag1;
                     r_divisor <= w_mag2;
                     r_cnt     <= '0;
                     r_dz      <= 1'b0;
                  end
               end
            end
            S_BYZERO: begin
               r_rem   <= '0;
               r_dvd   <= '0;
               r_neg_q <= 1'b0;
               r_neg_r <= 1'b0;
               r_dz    <= 1'b1;
               r_state <= S_END;
            end
            S_ON: begin
               if (annul_i || !start_i) begin
                  r_state <= S_FREE;
               end else begin
                  r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                  r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                  r_cnt <= r_cnt + C_CW'(1);
                  if (r_cnt == C_LAST) begin
                     r_state <= S_END;
                  end
               end
            end
            S_END: begin
               if (!start_i) begin
                  r_state    <= S_FREE;
                  result_o   <= '0;
                  ready_o    <= 1'b0;
                  div_zero_o <= 1'b0;
               end else begin
                  result_o   <= {w_rem_fix, w_quo_fix};
                  ready_o    <= 1'b1;
                  div_zero_o <= r_dz;
               end
            end
            default: begin
               r_state <= S_FREE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Self-checking bench for div_iter at WIDTH=32 and WIDTH=8,
//            compared against a plain-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        s32 = 1'b0, an32 = 1'b0, sg32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [63:0] res32;
   logic        rdy32, bz32, dz32;

   logic        s8 = 1'b0, an8 = 1'b0, sg8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] res8;
   logic        rdy8, bz8, dz8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_iter #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start_i(s32), .annul_i(an32), .signed_div_i(sg32),
      .opdata1_i(a32), .opdata2_i(b32), .result_o(res32), .ready_o(rdy32),
      .busy_o(bz32), .div_zero_o(dz32)
   );

   div_iter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start_i(s8), .annul_i(an8), .signed_div_i(sg8),
      .opdata1_i(a8), .opdata2_i(b8), .result_o(res8), .ready_o(rdy8),
      .busy_o(bz8), .div_zero_o(dz8)
   );

   // Reference: truncating integer division on sign-interpreted operands,
   // results wrapped to w bits. Returns {rem[31:0], quo[31:0]}.
   function automatic logic [63:0] ref_div(input int w, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
      longint ma, sa, sb, q, r;
      ma = (longint'(1) << w) - 1;
      sa = longint'(a) & ma;
      sb = longint'(b) & ma;
      if (sb == 0) return 64'd0;
      if (sgn) begin
         if (((sa >> (w - 1)) & 1) != 0) sa = sa - (longint'(1) << w);
         if (((sb >> (w - 1)) & 1) != 0) sb = sb - (longint'(1) << w);
      end
      q = sa / sb;
      r = sa % sb;
      return {32'(r & ma), 32'(q & ma)};
   endfunction

   // One full handshake on the chosen instance, checking latency, result,
   // div-zero flag, busy during the operation and the cleanup after start drops.
   task automatic run_op(input int w, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input string name);
      logic [63:0] exp_full, exp_res, act_res;
      logic        exp_dz, rdy, bz, dz;
      int          p, exp_lat;
      bit          seen, busy_bad;
      exp_full = ref_div(w, sgn, a, b);
      exp_dz   = (w == 32) ? (b == 32'd0) : (b[7:0] == 8'd0);
      exp_lat  = exp_dz ? 3 : w + 2;
      exp_res  = (w == 32) ? exp_full : {48'd0, exp_full[39:32], exp_full[7:0]};
      @(negedge clk);
      if (w == 32) begin s32 = 1'b1; sg32 = sgn; a32 = a; b32 = b; end
      else begin s8 = 1'b1; sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; end
      p = 0; seen = 0; busy_bad = 0;
      while (!seen && p < w + 10) begin
         @(posedge clk);
         p++;
         @(negedge clk);
         rdy = (w == 32) ? rdy32 : rdy8;
         bz  = (w == 32) ? bz32 : bz8;
         if (rdy) seen = 1;
         else if (!bz) busy_bad = 1;
      end
      act_res = (w == 32) ? res32 : {48'd0, res8};
      dz      = (w == 32) ? dz32 : dz8;
      checks++;
      if (!seen || p != exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d edges (seen=%0d) expected %0d", name, p, seen, exp_lat);
      end
      checks++;
      if (act_res !== exp_res) begin
         failures++;
         $display("FAIL %s result: got %h expected %h (a=%h b=%h sgn=%0d)", name, act_res, exp_res, a, b, sgn);
      end
      checks++;
      if (dz !== exp_dz) begin
         failures++;
         $display("FAIL %s div_zero: got %b expected %b", name, dz, exp_dz);
      end
      checks++;
      if (busy_bad) begin
         failures++;
         $display("FAIL %s busy: got 0 before ready expected 1", name);
      end
      if (w == 32) s32 = 1'b0; else s8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      act_res = (w == 32) ? res32 : {48'd0, res8};
      rdy     = (w == 32) ? rdy32 : rdy8;
      bz      = (w == 32) ? bz32 : bz8;
      dz      = (w == 32) ? dz32 : dz8;
      checks++;
      if (act_res !== 64'd0 || rdy !== 1'b0 || bz !== 1'b0 || dz !== 1'b0) begin
         failures++;
         $display("FAIL %s release: got res=%h rdy=%b busy=%b dz=%b expected all 0", name, act_res, rdy, bz, dz);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (res32 !== 64'd0 || rdy32 !== 1'b0 || bz32 !== 1'b0 || dz32 !== 1'b0 ||
          res8 !== 16'd0 || rdy8 !== 1'b0 || bz8 !== 1'b0 || dz8 !== 1'b0) begin
         failures++;
         $display("FAIL reset: got res32=%h rdy32=%b bz32=%b dz32=%b res8=%h rdy8=%b bz8=%b dz8=%b expected all 0",
                  res32, rdy32, bz32, dz32, res8, rdy8, bz8, dz8);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned_basic();
      run_op(32, 1'b0, 32'd100, 32'd7, "u100_7");
      run_op(32, 1'b0, $urandom, $urandom_range(1, 1000), "u_rand");
   endtask

   task automatic test_signed();
      run_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2");
      run_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, "s_7_m2");
      run_op(32, 1'b1, $urandom, $urandom | 32'h1, "s_rand");
   endtask

   task automatic test_overflow();
      run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");
      run_op(32, 1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1");
   endtask

   task automatic test_div_zero();
      run_op(32, 1'b0, $urandom, 32'd0, "u_div0");
      run_op(32, 1'b1, $urandom, 32'd0, "s_div0");
   endtask

   task automatic test_annul();
      bit ready_seen;
      ready_seen = 0;
      @(negedge clk);
      s32 = 1'b1; sg32 = 1'b0; a32 = $urandom; b32 = 32'd3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (rdy32) ready_seen = 1;
      end
      @(negedge clk);
      an32 = 1'b1;
      @(posedge clk);
      #1;
      if (rdy32) ready_seen = 1;
      checks++;
      if (bz32 !== 1'b0) begin
         failures++;
         $display("FAIL annul busy: got %b expected 0", bz32);
      end
      @(negedge clk);
      an32 = 1'b0;
      s32  = 1'b0;
      if (rdy32) ready_seen = 1;
      checks++;
      if (ready_seen || res32 !== 64'd0) begin
         failures++;
         $display("FAIL annul ready: got ready_seen=%0d res=%h expected 0", ready_seen, res32);
      end
      run_op(32, 1'b1, 32'hFFFF_FF9C, 32'd9, "after_annul");
   endtask

   task automatic test_random8();
      logic [31:0] a, b;
      logic        sgn;
      for (int i = 0; i < 1000; i++) begin
         a   = {24'd0, 8'($urandom)};
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = 32'h0000_00FF;
            2:       begin a = 32'h80; b = 32'h0000_00FF; end
            default: b = {24'd0, 8'($urandom)};
         endcase
         sgn = 1'($urandom);
         run_op(8, sgn, a, b, "rand8");
      end
   endtask

   task automatic test_async_reset();
      int p;
      // Reset pulse in the middle of ON, away from any clock edge.
      @(negedge clk);
      s8 = 1'b1; sg8 = 1'b1; a8 = 8'h9D; b8 = 8'h05;
      repeat (4) @(posedge clk);
      #2;
      checks++;
      if (bz8 !== 1'b1) begin
         failures++;
         $display("FAIL async_on pre: got busy=%b expected 1", bz8);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bz8 !== 1'b0 || rdy8 !== 1'b0 || res8 !== 16'd0 || dz8 !== 1'b0) begin
         failures++;
         $display("FAIL async_on: got busy=%b rdy=%b res=%h dz=%b expected all 0", bz8, rdy8, res8, dz8);
      end
      @(negedge clk);
      rst = 1'b0;
      s8  = 1'b0;
      // Reset pulse while a divide-by-zero result is being held in END.
      @(negedge clk);
      s8 = 1'b1; sg8 = 1'b0; a8 = 8'h33; b8 = 8'h00;
      p = 0;
      while (!rdy8 && p < 20) begin
         @(posedge clk);
         p++;
         @(negedge clk);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (p >= 20 || bz8 !== 1'b0 || rdy8 !== 1'b0 || res8 !== 16'd0 || dz8 !== 1'b0) begin
         failures++;
         $display("FAIL async_end: got p=%0d busy=%b rdy=%b res=%h dz=%b expected ready reached then all 0",
                  p, bz8, rdy8, res8, dz8);
      end
      @(negedge clk);
      rst = 1'b0;
      s8  = 1'b0;
      run_op(8, 1'b1, 32'h0000_0081, 32'h0000_0007, "after_rst");
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_overflow();
      test_div_zero();
      test_annul();
      test_random8();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
